sdram_byte_port: RTL and testbench
==================================

Name: sdram_byte_port

Overview:
- Initiator-side client of the `sdram_bus` interface, the requester end that feeds one priority channel of the SDRAM controller.
- Converts a byte-addressed 8-bit host port (loader, CPU bridge) into 16-bit word requests with byte masks.
- Holds one outstanding transaction and an optional single-word read cache, so repeated accesses to the same word skip SDRAM.

Parameters:
- ADDR_BITS, 22, width of the `sdram_bus` word address ({bank 2, column 8, row 12}); host byte address is ADDR_BITS+1 bits.

Ports:
- clk  input  1  system clock, same domain as the SDRAM controller.
- reset  input  1  asynchronous, active-high reset.
- host_valid  input  1  host request valid.
- host_ready  output  1  block can accept a request.
- host_we  input  1  1 = write, 0 = read.
- host_addr  input  ADDR_BITS+1  byte address; bit 0 selects the byte within the word.
- host_wdata  input  8  write byte.
- host_rvalid  output  1  one-cycle pulse, host_rdata valid.
- host_rdata  output  8  read byte.
- invalidate  input  1  drop cached word (external writer changed SDRAM).
- mem  sdram_bus.controller  —  drives req/address/we/wm/data_write; samples ack/data_read.

Behaviour:
- Reset values (asynchronous): state IDLE, host_ready=1, host_rvalid=0, host_rdata=0, mem.req=0, mem.we=0, mem.wm=2'b11, mem.address=0, mem.data_write=0, cache invalid.
- States are IDLE, REQ and WAIT.
- host_ready=1 only in IDLE; a transfer happens when host_valid && host_ready.
- Word address = host_addr[ADDR_BITS:1].
- Byte 0 (addr[0]=0) is data[7:0]; byte 1 is data[15:8].
- wm is active-high mask (drives DQM):
  - write byte 0 → wm=2'b10;
  - write byte 1 → wm=2'b01;
  - reads → wm=2'b00.
- data_write = {host_wdata, host_wdata}.
- Read hit (cache valid, tag equal): no SDRAM access, stay IDLE, host_rvalid=1 with the selected byte on the next cycle. host_ready stays 1, so back-to-back hits run one per cycle.
- Read miss or write: the transfer cycle registers address/we/wm/data_write → REQ.
- REQ: mem.req=1 for exactly one cycle → WAIT.
- address/we/wm/data_write must hold stable from REQ until ack, because the controller latches req and samples the fields later.
- WAIT: on mem.ack, return to IDLE next cycle.
  - Reads: capture mem.data_read in the ack cycle, fill cache (tag = word address, valid=1), host_rvalid=1 with the selected byte the cycle after ack.
  - Writes: no host_rvalid. On a cache hit, the cached byte is updated (write-through); on a miss the cache is unchanged.
- Latency:
  - hit: 1 cycle;
  - miss: req 1 cycle after accept, rvalid 1 cycle after ack;
  - write: host_ready high the cycle after ack.
- mem.req is never asserted again before the previous ack.
- invalidate clears valid in any state.
  - If coincident with a fill: invalidate wins (valid=0), but host data is still returned.
  - If coincident with a hit-accept: the hit is served from the current word, then valid=0.
- ack in IDLE or REQ (stray, or late after reset) is ignored.
- Reset mid-WAIT: returns to IDLE, no rvalid, cache invalid.
- Tag compare uses the full ADDR_BITS; there is no wrap-around aliasing.

Optional Feature:
- Macro SDRAM_BYTE_PORT_CACHE_EN.
- Defined: single-word read cache as described.
- Undefined:
  - no cache storage or tag; every read issues an SDRAM request;
  - invalidate is ignored;
  - writes never update cache;
  - all other timing is unchanged.

Decomposition:
- Shared sdram_pkg: SDRAM address width constants (ROW_BITS, COL_BITS, bank bits, derived ADDR_BITS), wm encoding constants (WM_NONE=2'b00, WM_LOW_ONLY=2'b10, WM_HIGH_ONLY=2'b01, WM_ALL=2'b11), and the state enum type.
- No sub-module is natural; the cache is one register pair and stays inline.

Test Plan:
- Write addr 0x000001 data 0xA5 → one req, address 0x000000, we=1, wm=2'b01, data_write=0xA5A5; host_ready high the cycle after ack.
- Read 0x000000 (cold) with a controller model that acks after 5 cycles returning 0x12A5 → one req, wm=2'b00; host_rvalid with host_rdata=0xA5 one cycle after ack.
- Read 0x000001 immediately after that → no req; host_rvalid next cycle with 0x12. Without SDRAM_BYTE_PORT_CACHE_EN, a req is issued instead.
- Write 0x000000 data 0x3C, then read 0x000000 → write req with wm=2'b10; the read hits and returns 0x3C with no req.
- invalidate asserted in the same cycle as a read-miss ack → data returned; a following read of the same word issues a new req.
- Assert reset during WAIT, then deliver the late ack → no host_rvalid, state IDLE, host_ready=1; the next read of the same word issues a req.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: address geometry, write-mask encodings and the
// byte-port state type.
package sdram_pkg;

  localparam int unsigned ROW_BITS       = 12;
  localparam int unsigned COL_BITS       = 8;
  localparam int unsigned BANK_BITS      = 2;
  localparam int unsigned SDRAM_ADDR_BITS = ROW_BITS + COL_BITS + BANK_BITS;

  // Write masks are active-high and drive DQM directly.
  localparam logic [1:0] WM_NONE      = 2'b00;
  localparam logic [1:0] WM_LOW_ONLY  = 2'b10;
  localparam logic [1:0] WM_HIGH_ONLY = 2'b01;
  localparam logic [1:0] WM_ALL       = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } port_state_e;

  // Byte 0 lives in data[7:0], byte 1 in data[15:8].
  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sdram_bus.sv
// Request/acknowledge link between an SDRAM client and the SDRAM controller.
interface sdram_bus #(
  parameter int unsigned ADDR_BITS = 22
);
  logic                 req;
  logic                 ack;
  logic                 we;
  logic [1:0]           wm;
  logic [ADDR_BITS-1:0] address;
  logic [15:0]          data_write;
  logic [15:0]          data_read;

  // Requester side: drives the request fields, samples ack and read data.
  modport controller (
    output req, address, we, wm, data_write,
    input  ack, data_read
  );

  // Memory-controller side.
  modport memory (
    input  req, address, we, wm, data_write,
    output ack, data_read
  );
endinterface

// File: rtl/sdram_byte_port.sv
// Byte-wide host port onto the 16-bit sdram_bus. One outstanding transaction.
// Optional single-word read cache enabled by defining SDRAM_BYTE_PORT_CACHE_EN.
module sdram_byte_port
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = SDRAM_ADDR_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             host_we,
  input  logic [ADDR_BITS:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic             host_rvalid,
  output logic [7:0]       host_rdata,
  input  logic             invalidate,
  sdram_bus.controller     mem
);

  port_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 we_q;
  logic [1:0]           wm_q;
  logic [15:0]          wdata_q;
  logic                 sel_q;
  logic                 rvalid_q;
  logic [7:0]           rdata_q;

  logic [ADDR_BITS-1:0] host_word;
  logic                 hit;
  logic [7:0]           cache_byte;
  logic                 ack_wait;

  assign host_word = host_addr[ADDR_BITS:1];
  assign ack_wait  = (state_q == StWait) && mem.ack;

  assign host_ready     = (state_q == StIdle);
  assign host_rvalid    = rvalid_q;
  assign host_rdata     = rdata_q;
  assign mem.req        = (state_q == StReq);
  assign mem.address    = addr_q;
  assign mem.we         = we_q;
  assign mem.wm         = wm_q;
  assign mem.data_write = wdata_q;

`ifdef SDRAM_BYTE_PORT_CACHE_EN
  logic                 cache_valid_q;
  logic [ADDR_BITS-1:0] cache_tag_q;
  logic [15:0]          cache_data_q;

  assign hit        = cache_valid_q && (cache_tag_q == host_word) && !host_we;
  assign cache_byte = select_byte(cache_data_q, host_addr[0]);

  // Cache: fill on read ack, write-through on write ack, invalidate always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      if (ack_wait) begin
        if (!we_q) begin
          cache_data_q  <= mem.data_read;
          cache_tag_q   <= addr_q;
          cache_valid_q <= 1'b1;
        end else if (cache_valid_q && (cache_tag_q == addr_q)) begin
          if (sel_q) cache_data_q[15:8] <= wdata_q[7:0];
          else       cache_data_q[7:0]  <= wdata_q[7:0];
        end
      end
      if (invalidate) cache_valid_q <= 1'b0;
    end
  end
`else
  logic unused_invalidate;

  assign hit               = 1'b0;
  assign cache_byte        = 8'h00;
  assign unused_invalidate = invalidate;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state: misses and writes take one REQ cycle, then wait for ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (host_valid && !hit) state_d = StReq;
      StReq:   state_d = StWait;
      StWait:  if (mem.ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields latch at accept and hold until the next accept; read data
  // returns from the cache on a hit or from the bus in the ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wm_q     <= WM_ALL;
      wdata_q  <= '0;
      sel_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if ((state_q == StIdle) && host_valid) begin
        if (hit) begin
          rvalid_q <= 1'b1;
          rdata_q  <= cache_byte;
        end else begin
          addr_q  <= host_word;
          we_q    <= host_we;
          wm_q    <= host_we ? (host_addr[0] ? WM_HIGH_ONLY : WM_LOW_ONLY) : WM_NONE;
          wdata_q <= {host_wdata, host_wdata};
          sel_q   <= host_addr[0];
        end
      end
      if (ack_wait && !we_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= select_byte(mem.data_read, sel_q);
      end
    end
  end

endmodule

// File: tb/tb_sdram_byte_port.sv
// Self-checking bench for sdram_byte_port against a word-level memory and
// cache model. Honours SDRAM_BYTE_PORT_CACHE_EN for its expectations.
module tb_sdram_byte_port;

`ifdef SDRAM_BYTE_PORT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid, host_ready, host_we, host_rvalid, invalidate;
  logic [22:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;

  sdram_bus #(.ADDR_BITS(22)) bus ();

  sdram_byte_port #(.ADDR_BITS(22)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .invalidate  (invalidate),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: SDRAM contents per word plus the expected cache word.
  logic [15:0] mem_model [logic [21:0]];
  bit          cvalid = 1'b0;
  logic [21:0] ctag   = '0;
  logic [15:0] cdata  = '0;

  // One host transaction with an inline controller model acking after delay.
  task automatic access(input bit we, input logic [22:0] addr, input logic [7:0] wd,
                        input int delay, input bit inv_acc, input bit inv_ack);
    logic [21:0] word;
    bit          sel, hit;
    logic [15:0] w;
    logic [7:0]  exp_b;
    logic [1:0]  exp_wm;
    word = addr[22:1];
    sel  = addr[0];
    hit  = CACHE_EN && !we && cvalid && (ctag == word);
    if (!mem_model.exists(word)) mem_model[word] = 16'($urandom);
    checks++;
    if (host_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before got %b exp 1", host_ready);
    end
    host_valid = 1'b1; host_we = we; host_addr = addr; host_wdata = wd; invalidate = inv_acc;
    @(negedge clk);
    host_valid = 1'b0; invalidate = 1'b0;
    if (hit) begin
      exp_b = sel ? cdata[15:8] : cdata[7:0];
      checks++;
      if (host_rvalid !== 1'b1 || host_rdata !== exp_b) begin
        errors++; $display("FAIL hit_data got %b/%h exp 1/%h", host_rvalid, host_rdata, exp_b);
      end
      checks++;
      if (bus.req !== 1'b0) begin
        errors++; $display("FAIL hit_noreq got %b exp 0", bus.req);
      end
      if (inv_acc) cvalid = 1'b0;
    end else begin
      if (inv_acc) cvalid = 1'b0;
      exp_wm = we ? (sel ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if (bus.req !== 1'b1) begin
        errors++; $display("FAIL req_pulse got %b exp 1", bus.req);
      end
      checks++;
      if (bus.address !== word || bus.we !== we || bus.wm !== exp_wm) begin
        errors++; $display("FAIL req_fields got %h/%b/%b exp %h/%b/%b",
                           bus.address, bus.we, bus.wm, word, we, exp_wm);
      end
      if (we) begin
        checks++;
        if (bus.data_write !== {wd, wd}) begin
          errors++; $display("FAIL data_write got %h exp %h", bus.data_write, {wd, wd});
        end
      end
      checks++;
      if (host_rvalid !== 1'b0) begin
        errors++; $display("FAIL rvalid_early got %b exp 0", host_rvalid);
      end
      @(negedge clk);
      checks++;
      if (bus.req !== 1'b0) begin
        errors++; $display("FAIL req_single got %b exp 0", bus.req);
      end
      repeat (delay) begin
        @(negedge clk);
        checks++;
        if (bus.req !== 1'b0 || bus.address !== word || bus.wm !== exp_wm ||
            host_ready !== 1'b0) begin
          errors++; $display("FAIL wait_hold got %b/%h/%b/%b exp 0/%h/%b/0",
                             bus.req, bus.address, bus.wm, host_ready, word, exp_wm);
        end
      end
      bus.ack = 1'b1;
      bus.data_read = we ? 16'($urandom) : mem_model[word];
      invalidate = inv_ack;
      @(negedge clk);
      bus.ack = 1'b0; invalidate = 1'b0; bus.data_read = 16'($urandom);
      if (we) begin
        w = mem_model[word];
        if (sel) w[15:8] = wd; else w[7:0] = wd;
        mem_model[word] = w;
        if (CACHE_EN && cvalid && ctag == word) begin
          if (sel) cdata[15:8] = wd; else cdata[7:0] = wd;
        end
        checks++;
        if (host_rvalid !== 1'b0) begin
          errors++; $display("FAIL write_no_rvalid got %b exp 0", host_rvalid);
        end
      end else begin
        w = mem_model[word];
        exp_b = sel ? w[15:8] : w[7:0];
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== exp_b) begin
          errors++; $display("FAIL miss_data got %b/%h exp 1/%h", host_rvalid, host_rdata, exp_b);
        end
        if (CACHE_EN) begin
          cdata = w; ctag = word; cvalid = 1'b1;
        end
      end
      if (inv_ack) cvalid = 1'b0;
      checks++;
      if (host_ready !== 1'b1) begin
        errors++; $display("FAIL ready_after_ack got %b exp 1", host_ready);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (host_ready !== 1'b1 || host_rvalid !== 1'b0 || host_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_host got %b/%b/%h exp 1/0/00",
                         host_ready, host_rvalid, host_rdata);
    end
    checks++;
    if (bus.req !== 1'b0 || bus.we !== 1'b0 || bus.wm !== 2'b11 ||
        bus.address !== 22'h0 || bus.data_write !== 16'h0) begin
      errors++; $display("FAIL reset_bus got %b/%b/%b/%h/%h exp 0/0/11/0/0",
                         bus.req, bus.we, bus.wm, bus.address, bus.data_write);
    end
  endtask

  task automatic test_plan_sequence();
    access(1'b1, 23'h000001, 8'hA5, 3, 1'b0, 1'b0);
    mem_model[22'h0] = 16'h12A5;
    access(1'b0, 23'h000000, 8'h00, 4, 1'b0, 1'b0);
    access(1'b0, 23'h000001, 8'h00, 2, 1'b0, 1'b0);
    access(1'b1, 23'h000000, 8'h3C, 1, 1'b0, 1'b0);
    access(1'b0, 23'h000000, 8'h00, 1, 1'b0, 1'b0);
  endtask

  task automatic test_invalidate();
    access(1'b0, 23'h00000A, 8'h00, 2, 1'b0, 1'b1);
    access(1'b0, 23'h00000B, 8'h00, 1, 1'b0, 1'b0);
    access(1'b0, 23'h00000C, 8'h00, 0, 1'b0, 1'b0);
    access(1'b0, 23'h00000D, 8'h00, 0, 1'b1, 1'b0);
    access(1'b0, 23'h00000C, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_tag_full();
    access(1'b0, 23'h000004, 8'h00, 1, 1'b0, 1'b0);
    access(1'b0, 23'h400004, 8'h00, 1, 1'b0, 1'b0);
    access(1'b0, 23'h000005, 8'h00, 1, 1'b0, 1'b0);
  endtask

  task automatic test_stray_ack();
    bus.ack = 1'b1; bus.data_read = 16'hBEEF;
    @(negedge clk);
    bus.ack = 1'b0;
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b0 || host_ready !== 1'b1 || bus.req !== 1'b0) begin
      errors++; $display("FAIL stray_ack got %b/%b/%b exp 0/1/0",
                         host_rvalid, host_ready, bus.req);
    end
  endtask

  task automatic test_back_to_back();
`ifdef SDRAM_BYTE_PORT_CACHE_EN
    access(1'b0, 23'h00000E, 8'h00, 1, 1'b0, 1'b0);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 23'h00000E;
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== cdata[7:0] || host_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %b/%h/%b exp 1/%h/1",
                         host_rvalid, host_rdata, host_ready, cdata[7:0]);
    end
    host_addr = 23'h00000F;
    @(negedge clk);
    host_valid = 1'b0;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== cdata[15:8] || bus.req !== 1'b0) begin
      errors++; $display("FAIL b2b_second got %b/%h/%b exp 1/%h/0",
                         host_rvalid, host_rdata, bus.req, cdata[15:8]);
    end
`else
    access(1'b1, 23'h00000E, 8'h5A, 0, 1'b0, 1'b0);
    access(1'b0, 23'h00000E, 8'h00, 0, 1'b0, 1'b0);
    access(1'b0, 23'h00000F, 8'h00, 0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_wait();
    if (!mem_model.exists(22'h8)) mem_model[22'h8] = 16'($urandom);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 23'h000010;
    @(negedge clk);
    host_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (host_ready !== 1'b1 || host_rvalid !== 1'b0 || bus.req !== 1'b0 ||
        bus.wm !== 2'b11 || bus.address !== 22'h0) begin
      errors++; $display("FAIL reset_mid_wait got %b/%b/%b/%b/%h exp 1/0/0/11/0",
                         host_ready, host_rvalid, bus.req, bus.wm, bus.address);
    end
    cvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.ack = 1'b1; bus.data_read = mem_model[22'h8];
    @(negedge clk);
    bus.ack = 1'b0;
    checks++;
    if (host_rvalid !== 1'b0 || host_ready !== 1'b1 || bus.req !== 1'b0) begin
      errors++; $display("FAIL late_ack got %b/%b/%b exp 0/1/0",
                         host_rvalid, host_ready, bus.req);
    end
    access(1'b0, 23'h000010, 8'h00, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [21:0] word;
    for (int i = 0; i < 60; i++) begin
      word = 22'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) word = word | 22'h200000;
      access($urandom_range(0, 2) == 0, {word, 1'($urandom_range(0, 1))},
             8'($urandom), $urandom_range(0, 4),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; invalidate = 1'b0;
    bus.ack = 1'b0; bus.data_read = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_plan_sequence();
    test_invalidate();
    test_tag_full();
    test_stray_ack();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
